// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: default geometry and the
// refill FSM state encoding.
package inst_cache_pkg;

  localparam int unsigned ICACHE_INDEX_BITS = 6;  // 64 lines
  localparam int unsigned ICACHE_WORD_BITS  = 2;  // 4 words (16 bytes) per line

  typedef enum logic {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped instruction cache, with a
// combinational hit compare on the lookup port.
//   clk, rst            clock, synchronous active-high reset (clears valid bits)
//   lookup_index_i/_tag_i  index/tag of the address being looked up
//   hit_o               lookup line is valid and its tag matches
//   wr_en_i             install wr_tag_i at wr_index_i and mark it valid
module icache_tag_array
  import inst_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int unsigned TAG_BITS   = 32 - 2 - ICACHE_WORD_BITS - ICACHE_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] lookup_index_i,
  input  logic [TAG_BITS-1:0]   lookup_tag_i,
  output logic                  hit_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q [LINES];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // NOTE: tag storage is deliberately not reset; the valid bits alone gate
  // hits, and leaving the array reset-free lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  assign hit_o = valid_q[lookup_index_i] && (tag_q[lookup_index_i] == lookup_tag_i);

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache between the fetcher and the
// memory-controller arbiter. Misses refill a whole line as a burst of
// single-word request/ready handshakes.
//   clk, rst        clock, synchronous active-high reset
//   rdy             global ready; when low every register holds
//   flush           mispredict reset; suppresses the response in IDLE
//   fetch_enable    fetcher request, cache_pc held stable while high
//   cache_pc        byte address of the instruction (bits [1:0] ignored)
//   cache_valid     registered: cache_inst holds the word at cache_pc
//   cache_inst      registered instruction word
//   mem_req         word read request to the memory controller
//   mem_addr        word-aligned byte address of the requested word
//   mem_ready       one-cycle pulse, mem_word valid
//   mem_word        returned word
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int unsigned WORD_BITS  = ICACHE_WORD_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        fetch_enable,
  input  logic [31:0] cache_pc,
  output logic        cache_valid,
  output logic [31:0] cache_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_word
);

  localparam int unsigned IDX_LSB  = 2 + WORD_BITS;
  localparam int unsigned TAG_LSB  = IDX_LSB + INDEX_BITS;
  localparam int unsigned TAG_BITS = 32 - TAG_LSB;
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << WORD_BITS;

  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [WORD_BITS-1:0]  pc_off;
  logic                  unused_pc_bits;

  assign pc_tag         = cache_pc[31:TAG_LSB];
  assign pc_idx         = cache_pc[TAG_LSB-1:IDX_LSB];
  assign pc_off         = cache_pc[IDX_LSB-1:2];
  assign unused_pc_bits = ^cache_pc[1:0];

  icache_state_e         state_q;
  logic [WORD_BITS-1:0]  cnt_q;
  logic [TAG_BITS-1:0]   miss_tag_q;
  logic [INDEX_BITS-1:0] miss_idx_q;
  logic                  cache_valid_q;
  logic [31:0]           cache_inst_q;
  logic                  mem_req_q;
  logic [31:0]           mem_addr_q;

  logic [31:0] data_q [LINES][WORDS];

  logic hit;
  logic fill_we;
  logic line_done;

  // Refill writes always target the latched miss line, never live cache_pc.
  assign fill_we   = rdy && (state_q == ICACHE_REFILL) && mem_ready;
  assign line_done = fill_we && (cnt_q == '1);

  icache_tag_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_tags (
    .clk            (clk),
    .rst            (rst),
    .lookup_index_i (pc_idx),
    .lookup_tag_i   (pc_tag),
    .hit_o          (hit),
    .wr_en_i        (line_done),
    .wr_index_i     (miss_idx_q),
    .wr_tag_i       (miss_tag_q)
  );

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[miss_idx_q][cnt_q] <= mem_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ICACHE_IDLE;
      cnt_q         <= '0;
      miss_tag_q    <= '0;
      miss_idx_q    <= '0;
      cache_valid_q <= 1'b0;
      cache_inst_q  <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else if (rdy) begin
      unique case (state_q)
        ICACHE_IDLE: begin
          if (flush) begin
            cache_valid_q <= 1'b0;
          end else if (fetch_enable) begin
            if (hit) begin
              // Re-issued every cycle the request stays up, so a stalled
              // fetcher keeps seeing the word.
              cache_valid_q <= 1'b1;
              cache_inst_q  <= data_q[pc_idx][pc_off];
            end else begin
              cache_valid_q <= 1'b0;
              miss_tag_q    <= pc_tag;
              miss_idx_q    <= pc_idx;
              cnt_q         <= '0;
              mem_req_q     <= 1'b1;
              mem_addr_q    <= {cache_pc[31:IDX_LSB], {WORD_BITS{1'b0}}, 2'b00};
              state_q       <= ICACHE_REFILL;
            end
          end else begin
            cache_valid_q <= 1'b0;
          end
        end
        ICACHE_REFILL: begin
          // The burst always runs to completion; flush and request changes
          // are only acted on back in IDLE.
          cache_valid_q <= 1'b0;
          if (mem_ready) begin
            if (cnt_q == '1) begin
              mem_req_q <= 1'b0;
              state_q   <= ICACHE_IDLE;
            end else begin
              cnt_q      <= cnt_q + WORD_BITS'(1);
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
        default: state_q <= ICACHE_IDLE;
      endcase
    end
  end

  assign cache_valid = cache_valid_q;
  assign cache_inst  = cache_inst_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_inst_cache.sv
// Randomised scoreboard bench for inst_cache. The driver predicts hit/miss
// from a line-residency model and queues expected responses (stamped with
// the cycle they must appear) and expected refill addresses; a monitor and a
// memory responder pop and compare independently.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        fetch_enable;
  logic [31:0] cache_pc;
  logic        cache_valid;
  logic [31:0] cache_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_word;

  inst_cache dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .fetch_enable (fetch_enable),
    .cache_pc     (cache_pc),
    .cache_valid  (cache_valid),
    .cache_inst   (cache_inst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_word     (mem_word)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Backing memory: a few fixed words, everything else a function of address.
  logic [31:0] mem_init [logic [31:0]];
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (mem_init.exists(a)) return mem_init[a];
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Residency model: which 16-byte line base sits in each of the 64 slots.
  logic [31:0] resident [64];
  bit          resident_v [64];

  typedef struct {
    int          cyc;
    logic [31:0] inst;
  } exp_t;
  exp_t        exp_q [$];
  logic [31:0] addr_q [$];

  int fills_done     = 0;
  int burst_words    = 0;
  int last_grant_cyc = 0;
  int gap            = 0;
  int gap_fixed      = 2;
  bit stall_req      = 1'b0;
  bit rand_stalls    = 1'b0;

  function automatic int next_gap();
    if (gap_fixed >= 0) return gap_fixed;
    return int'($urandom_range(3));
  endfunction

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check("resp_missed_cycle", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        check("resp_valid", 32'(cache_valid), 32'd1);
        check("resp_inst", cache_inst, exp_q[0].inst);
        void'(exp_q.pop_front());
      end else if (cache_valid) begin
        check("spurious_valid", 32'(cache_valid), 32'd0);
      end
    end
  end

  // Memory responder: grants words after a gap, checks burst addresses,
  // and occasionally drops rdy for three cycles mid-refill.
  initial begin
    logic [31:0] exp_a;
    rdy       = 1'b1;
    mem_ready = 1'b0;
    mem_word  = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst) begin
        burst_words = 0;
        addr_q.delete();
        gap = next_gap();
      end else if (mem_req) begin
        if (addr_q.size() != 0 && (stall_req || (rand_stalls && $urandom_range(15) == 0))) begin
          stall_req = 1'b0;
          rdy = 1'b0;
          for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_mem_req", 32'(mem_req), 32'd1);
            check("stall_mem_addr", mem_addr, addr_q[0]);
          end
          rdy = 1'b1;
        end else if (gap > 0) begin
          gap--;
        end else begin
          if (addr_q.size() == 0) begin
            check("mem_req_unexpected", 32'(mem_req), 32'd0);
            exp_a = mem_addr;
          end else begin
            exp_a = addr_q.pop_front();
            check("mem_addr", mem_addr, exp_a);
          end
          mem_word  = memf(exp_a);
          mem_ready = 1'b1;
          burst_words++;
          if (burst_words == 4) begin
            burst_words    = 0;
            last_grant_cyc = cyc;
            fills_done++;
          end
          gap = next_gap();
        end
      end
    end
  end

  // One fetch transaction. Called at a negedge; returns at a negedge.
  task automatic fetch(input logic [31:0] pc, input int hold, input bit abandon, input bit use_flush);
    logic [31:0] base;
    int idx, c, resp, target, guard;
    base = {pc[31:4], 4'h0};
    idx  = int'(pc[9:4]);
    fetch_enable = 1'b1;
    cache_pc     = pc;
    c = cyc;
    if (resident_v[idx] && resident[idx] == base) begin
      for (int k = 1; k <= hold; k++) exp_q.push_back('{cyc: c + k, inst: memf({pc[31:2], 2'b00})});
      repeat (hold) @(negedge clk);
      fetch_enable = 1'b0;
    end else begin
      for (int w = 0; w < 4; w++) addr_q.push_back(base + 32'(4 * w));
      resident_v[idx] = 1'b1;
      resident[idx]   = base;
      target = fills_done + 1;
      if (abandon) begin
        guard = 0;
        while (burst_words < 2 && fills_done < target && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        flush        = use_flush;
        fetch_enable = 1'b0;
        cache_pc     = pc ^ 32'h0000_1000;
        @(negedge clk);
        flush = 1'b0;
      end
      guard = 0;
      while (fills_done < target && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      check("refill_completed", 32'(fills_done >= target), 32'd1);
      if (abandon) begin
        repeat (2) @(negedge clk);
      end else begin
        // Last word lands at the next edge; the lookup one edge later hits.
        resp = last_grant_cyc + 2;
        for (int k = 0; k < hold; k++) exp_q.push_back('{cyc: resp + k, inst: memf({pc[31:2], 2'b00})});
        while (cyc < resp + hold - 1) @(negedge clk);
        fetch_enable = 1'b0;
      end
    end
  endtask

  // Flush and a hitting request in the same cycle: flush wins, the response
  // comes from the following cycle.
  task automatic flush_with_fetch(input logic [31:0] pc);
    int c;
    c = cyc;
    fetch_enable = 1'b1;
    cache_pc     = pc;
    flush        = 1'b1;
    exp_q.push_back('{cyc: c + 2, inst: memf({pc[31:2], 2'b00})});
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    fetch_enable = 1'b0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 64; i++) resident_v[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    logic [31:0] pc;
    mem_init[32'h100] = 32'h11;
    mem_init[32'h104] = 32'h22;
    mem_init[32'h108] = 32'h33;
    mem_init[32'h10C] = 32'h44;
    reset_model();
    rst = 1'b1;
    flush = 1'b0;
    fetch_enable = 1'b0;
    cache_pc = '0;
    repeat (3) @(negedge clk);
    check("reset_cache_valid", 32'(cache_valid), 32'd0);
    check("reset_cache_inst", cache_inst, 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    fetch(32'h0000_0104, 1, 1'b0, 1'b0);  // cold miss, 2-cycle gaps
    fetch(32'h0000_0108, 1, 1'b0, 1'b0);  // hit
    fetch(32'h0000_0504, 1, 1'b0, 1'b0);  // conflict on index 0x10
    fetch(32'h0000_0104, 1, 1'b0, 1'b0);  // evicted, misses again
    fetch(32'h0000_0200, 1, 1'b1, 1'b1);  // flush mid-refill
    fetch(32'h0000_020C, 1, 1'b0, 1'b0);  // installed line hits
    fetch(32'h0000_020C, 5, 1'b0, 1'b0);  // stalled fetcher, 5 cycles
    flush_with_fetch(32'h0000_0208);
    gap_fixed = 1;
    stall_req = 1'b1;
    fetch(32'h0000_0304, 2, 1'b0, 1'b0);  // rdy low mid-refill

    // rst during a refill.
    fetch_enable = 1'b1;
    cache_pc     = 32'h0000_0400;
    for (int w = 0; w < 4; w++) addr_q.push_back(32'h400 + 32'(4 * w));
    guard = 0;
    while (burst_words < 1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    rst = 1'b1;
    fetch_enable = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    check("rst_mid_valid", 32'(cache_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    @(negedge clk);
    fetch(32'h0000_020C, 1, 1'b0, 1'b0);  // previously filled, now misses

    // Randomised traffic over a small set of conflicting lines.
    gap_fixed   = -1;
    rand_stalls = 1'b1;
    for (int i = 0; i < 150; i++) begin
      pc = (32'($urandom_range(3)) << 10) | (32'($urandom_range(7)) << 4) | (32'($urandom_range(3)) << 2);
      fetch(pc, int'($urandom_range(1, 3)), ($urandom_range(9) == 0), 1'($urandom_range(1)));
      if ($urandom_range(3) == 0) @(negedge clk);
    end
    rand_stalls = 1'b0;

    repeat (6) @(negedge clk);
    check("pending_responses", 32'(exp_q.size()), 32'd0);
    check("pending_mem_words", 32'(addr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Instruction-side cache that responds to the instruction fetcher's fetch_enable/cache_pc request and returns cache_valid/cache_inst.
- Direct-mapped and read-only. Refills one line at a time from the memory controller using a word-by-word request/ready handshake.
- Sits between the instruction fetcher and the memory-controller arbiter, on the instruction port.

Parameters:
INDEX_BITS, 6, number of line-index bits (2^6 = 64 lines)
WORD_BITS, 2, word-offset bits per line (2^2 = 4 words = 16 bytes per line)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rdy  input  1  global ready; when low, all state and outputs hold
flush  input  1  ROB mispredict reset (should_reset); cancels any pending response
fetch_enable  input  1  fetcher request; held high with stable cache_pc until it consumes a response
cache_pc  input  32  byte address of the requested instruction; bits [1:0] are ignored
cache_valid  output  1  registered; cache_inst holds the word at cache_pc
cache_inst  output  32  registered instruction word
mem_req  output  1  word read request to the memory controller
mem_addr  output  32  word-aligned byte address of the requested word
mem_ready  input  1  one-cycle pulse; mem_word is valid
mem_word  input  32  returned word

Behaviour:
- Address split: tag = pc[31:2+WORD_BITS+INDEX_BITS]; index = pc[2+WORD_BITS+INDEX_BITS-1:2+WORD_BITS]; word offset = pc[2+WORD_BITS-1:2].
- Storage per line: valid bit, tag, and 2^WORD_BITS data words. Valid bits clear on rst only; data and tags are not reset.
- Reset values: cache_valid=0, cache_inst=0, mem_req=0, mem_addr=0, state=IDLE, refill word counter=0, all valid bits=0.
- ~rdy has priority below rst: nothing changes, and mem_req/mem_addr hold.

State IDLE:
- flush: cache_valid<=0, stay in IDLE.
- fetch_enable & hit: cache_valid<=1, cache_inst<=line word. Each hit response appears the cycle after the request is sampled (1-cycle hit latency).
- The response is re-asserted every cycle while fetch_enable stays high, so a fetcher stalled by issue_stall still sees it.
- fetch_enable & miss: cache_valid<=0; latch the miss tag and index; counter<=0; mem_req<=1; mem_addr<={pc[31:2+WORD_BITS], counter, 2'b00}; go to REFILL.
- ~fetch_enable: cache_valid<=0.

State REFILL:
- cache_valid held 0.
- On mem_ready: write mem_word into data[index][counter].
- If counter is not the last word: counter+1, mem_req stays 1, and mem_addr advances by 4 in the same cycle.
- If counter is the last word: mem_req<=0, valid<=1, tag<=miss tag, go to IDLE. The next request is looked up next cycle, which makes it a hit.
- mem_req never drops mid-line. The memory controller sees a contiguous 4-word burst of single-word handshakes.

Boundary conditions:
- flush during REFILL: the refill completes (memory protocol is never abandoned) and the line is installed. No response is produced for the old pc. After return to IDLE, the fetcher's new request is served normally.
- fetch_enable dropping or cache_pc changing during REFILL: the same handling applies. Responses are only ever generated in IDLE from the current request.
- rst mid-REFILL: immediate return to IDLE, mem_req=0, all lines invalid. The memory controller must tolerate request withdrawal on rst.
- Simultaneous flush and fetch_enable in IDLE: flush wins and no response is given that cycle.
- A new request to the line currently being refilled is not forwarded; it waits for IDLE.
- Index and tag are taken from the latched miss address, never from live cache_pc.

Decomposition:
- Shared const_def additions: ICACHE_IDLE/ICACHE_REFILL state encodings and default INDEX_BITS/WORD_BITS.
- One natural sub-module, icache_tag_array: valid and tag storage with combinational hit compare. The data array stays in inst_cache.

Test Plan:
- Cold miss: rst, then fetch_enable=1, cache_pc=0x00000104 → mem_req with mem_addr 0x100, 0x104, 0x108, 0x10C. Memory returns 0x11,0x22,0x33,0x44 with 2-cycle ready gaps → after the last word, IDLE; the next cycle has cache_valid=1, cache_inst=0x22.
- Hit latency: pc 0x108 after the fill → cache_valid=1, cache_inst=0x33 exactly 1 cycle after sampling, with no mem_req.
- Conflict: pc 0x00000504 (same index 0x10, different tag) → refill 0x500–0x50C. A later pc 0x104 misses again.
- Flush mid-refill: assert flush during word 2 of a miss to 0x200 and drop fetch_enable → no cache_valid, line installed. The next request 0x20C hits 1 cycle later.
- Stall hold: on a hit, keep fetch_enable high for 5 cycles → cache_valid stays 1 with a stable cache_inst. rdy=0 for 3 cycles mid-refill → mem_req/mem_addr/counter frozen.
- rst mid-refill → mem_req=0 next cycle. Re-request of a previously filled pc misses.
